eth_tx_arbiter: RTL

//  Frame-granular round-robin arbiter sharing the Ethernet TX AXI-Stream path among NUM_SRC sources.

---
 rtl/eth_tx_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arbiter
// Brief    : Frame-granular round-robin arbiter sharing one AXI-Stream TX path
//            among NUM_SRC sources, with truncation of oversized frames.
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BEATS = 384
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [NUM_SRC-1:0]         src_enable,
    input  logic [32*NUM_SRC-1:0]      s_axis_tdata,
    input  logic [NUM_SRC-1:0]         s_axis_tvalid,
    input  logic [NUM_SRC-1:0]         s_axis_tlast,
    output logic [NUM_SRC-1:0]         s_axis_tready,
    output logic [31:0]                m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_trunc
);

    localparam int c_GW = $clog2(NUM_SRC);
    localparam int c_CW = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_XFER  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [c_GW-1:0] c_LAST_RST = c_GW'(NUM_SRC - 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(MAX_BEATS - 1);

    logic [1:0]      r_state;
    logic [c_GW-1:0] r_grant;
    logic [c_GW-1:0] r_last_grant;
    logic [c_CW-1:0] r_beat_cnt;
    logic            r_err_trunc;

    logic [1:0]      w_state_nxt;
    logic [c_GW-1:0] w_grant_nxt;
    logic [c_GW-1:0] w_last_grant_nxt;
    logic [c_CW-1:0] w_beat_cnt_nxt;
    logic            w_err_trunc_nxt;

    logic [NUM_SRC-1:0] w_req;
    logic               w_found;
    logic [c_GW-1:0]    w_pick;
    logic               w_g_valid;
    logic               w_g_last;
    logic [31:0]        w_g_data;
    logic               w_at_max;
    logic               w_hs;

    assign w_req     = s_axis_tvalid & src_enable;
    assign w_g_valid = s_axis_tvalid[r_grant];
    assign w_g_last  = s_axis_tlast[r_grant];
    assign w_g_data  = s_axis_tdata[32*int'(r_grant) +: 32];
    assign w_at_max  = (r_beat_cnt == c_CNT_LAST);
    assign w_hs      = (r_state == c_XFER) & w_g_valid & m_axis_tready;

    // Round-robin search starts one past the last served source and wraps
    // modulo NUM_SRC, which need not be a power of two.
    always_comb begin
        int w_idx;
        w_idx   = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_SRC;
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = c_GW'(w_idx);
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (r_state)
            c_XFER: begin
                m_axis_tdata           = w_g_data;
                m_axis_tvalid          = w_g_valid;
                m_axis_tlast           = w_g_last | w_at_max;
                s_axis_tready[r_grant] = m_axis_tready;
            end
            c_DRAIN: begin
                s_axis_tready[r_grant] = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_err_trunc_nxt  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_grant_nxt    = w_pick;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = c_XFER;
                end
            end
            c_XFER: begin
                if (w_hs) begin
                    w_beat_cnt_nxt = r_beat_cnt + c_CW'(1);
                    if (w_g_last) begin
                        w_last_grant_nxt = r_grant;
                        w_state_nxt      = c_IDLE;
                    end else if (w_at_max) begin
                        // Forced tlast went out; swallow the rest of this frame.
                        w_err_trunc_nxt  = 1'b1;
                        w_last_grant_nxt = r_grant;
                        w_state_nxt      = c_DRAIN;
                    end
                end
            end
            c_DRAIN: begin
                if (w_g_valid && w_g_last) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= c_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_LAST_RST;
            r_beat_cnt   <= '0;
            r_err_trunc  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_err_trunc  <= w_err_trunc_nxt;
        end
    end

    assign grant_id  = r_grant;
    assign busy      = (r_state != c_IDLE);
    assign err_trunc = r_err_trunc;

endmodule
`default_nettype wire
